axis_deltasigma_decim: RTL and testbench



---
 rtl/axis_deltasigma_decim.sv | 123 ++++++++++++
 tb/tb_axis_deltasigma_decim.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_deltasigma_decim.sv
// axis_deltasigma_decim: multi-channel delta-sigma boxcar decimator with AXI4-Stream frame output
module axis_deltasigma_decim #(
  parameter int AXIS_TDATA_WIDTH    = 16,
  parameter int NUM_CH              = 4,
  parameter int DECIM               = 64,
  parameter int TWOS_COMPL          = 1,
  parameter int CLOCK_DETECT_CYCLES = 255,
  parameter int OVR_CNT_WIDTH       = 16
) (
  input  logic                                          m_axis_aclk,
  input  logic                                          m_axis_areset,
  input  logic                                          m_axis_tready,
  output logic                                          m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]                   m_axis_tdata,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0]  m_axis_tuser,
  output logic                                          m_axis_tlast,
  input  logic                                          ds_clk_i,
  input  logic [NUM_CH-1:0]                             ds_data_i,
  input  logic                                          enable,
  output logic                                          clk_detect,
  output logic [OVR_CNT_WIDTH-1:0]                      overrun_cnt
);
  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int UW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(CLOCK_DETECT_CYCLES + 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync;
  logic clk_sync_d;
  logic [NUM_CH-1:0] data_s1, data_s2;
  logic pulse, frame_done, hs, last_ch, load;
  logic [SW-1:0] scnt;
  logic [W-1:0] acc [NUM_CH];
  logic [W-1:0] sum [NUM_CH];
  logic [W-1:0] fbuf [NUM_CH];
  logic [UW-1:0] ch, ch_n;
  logic [CW-1:0] det_cnt;

  assign pulse      = clk_sync[1] & ~clk_sync_d;
  assign frame_done = pulse & enable & (scnt == SW'(DECIM - 1));
  assign last_ch    = ch == UW'(NUM_CH - 1);
  assign hs         = m_axis_tvalid & m_axis_tready;
  assign load       = frame_done & (state == IDLE | (hs & last_ch));

  assign m_axis_tvalid = state == SEND;
  assign m_axis_tdata  = fbuf[ch];
  assign m_axis_tuser  = ch;
  assign m_axis_tlast  = m_axis_tvalid & last_ch;
  assign clk_detect    = det_cnt < CW'(CLOCK_DETECT_CYCLES);

  // Clock and data lines share identical two-flop synchronisers so a bit stays aligned with its edge
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      clk_sync   <= '0;
      clk_sync_d <= 1'b0;
      data_s1    <= '0;
      data_s2    <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ds_clk_i};
      clk_sync_d <= clk_sync[1];
      data_s1    <= ds_data_i;
      data_s2    <= data_s1;
    end
  end

  // Per-channel running sum including the bit sampled on the current edge
  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      sum[k] = acc[k] + (data_s2[k] ? W'(1) : {W{TWOS_COMPL != 0}});
  end

  // Boxcar accumulation; disabling acquisition discards any partial frame
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset || !enable) begin
      scnt <= '0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (pulse) begin
      scnt <= frame_done ? '0 : scnt + SW'(1);
      for (int k = 0; k < NUM_CH; k++) acc[k] <= frame_done ? '0 : sum[k];
    end
  end

  // Output FSM next state: a new frame may take over right on the last-beat handshake
  always_comb begin
    state_n = state;
    ch_n    = ch;
    if (load) begin
      state_n = SEND;
      ch_n    = '0;
    end else if (hs) begin
      state_n = last_ch ? IDLE : SEND;
      ch_n    = last_ch ? '0 : ch + UW'(1);
    end
  end

  // Output FSM state, frame buffer and saturating overrun count
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state       <= IDLE;
      ch          <= '0;
      overrun_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) fbuf[k] <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      if (load)
        for (int k = 0; k < NUM_CH; k++) fbuf[k] <= sum[k];
      if (frame_done && !load && !(&overrun_cnt))
        overrun_cnt <= overrun_cnt + OVR_CNT_WIDTH'(1);
    end
  end

  // Modulator clock watchdog; starts saturated so no clock is reported until an edge is seen
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset)
      det_cnt <= CW'(CLOCK_DETECT_CYCLES);
    else if (pulse)
      det_cnt <= '0;
    else if (det_cnt != CW'(CLOCK_DETECT_CYCLES))
      det_cnt <= det_cnt + CW'(1);
  end
endmodule

// File: tb/tb_axis_deltasigma_decim.sv
// tb_axis_deltasigma_decim: directed vector bench for the delta-sigma decimator
module tb_axis_deltasigma_decim;
  logic clk = 0, rst = 1, tready = 0, ds_clk = 0, enable = 0, sel = 0;
  logic [1:0] ds_data = 0;
  logic tv0, tl0, tu0, cd0, tv1, tl1, tu1, cd1;
  logic [7:0] td0, td1;
  logic [15:0] ov0, ov1;
  logic tv, tu, tl;
  logic [7:0] td;
  int nvec = 0, nerr = 0, cyc = 0;

  typedef struct {logic [7:0] d; logic u; logic l; int c;} beat_t;
  typedef struct {logic [3:0] c0; logic [3:0] c1; logic u; logic [7:0] e0; logic [7:0] e1;} vec_t;
  beat_t q[$];
  vec_t vt[5];

  always #5 clk = ~clk;

  axis_deltasigma_decim #(.AXIS_TDATA_WIDTH(8), .NUM_CH(2), .DECIM(4), .TWOS_COMPL(1),
    .CLOCK_DETECT_CYCLES(255), .OVR_CNT_WIDTH(16)) dut0 (
    .m_axis_aclk(clk), .m_axis_areset(rst), .m_axis_tready(tready), .m_axis_tvalid(tv0),
    .m_axis_tdata(td0), .m_axis_tuser(tu0), .m_axis_tlast(tl0), .ds_clk_i(ds_clk),
    .ds_data_i(ds_data), .enable(enable), .clk_detect(cd0), .overrun_cnt(ov0));

  axis_deltasigma_decim #(.AXIS_TDATA_WIDTH(8), .NUM_CH(2), .DECIM(4), .TWOS_COMPL(0),
    .CLOCK_DETECT_CYCLES(255), .OVR_CNT_WIDTH(16)) dut1 (
    .m_axis_aclk(clk), .m_axis_areset(rst), .m_axis_tready(tready), .m_axis_tvalid(tv1),
    .m_axis_tdata(td1), .m_axis_tuser(tu1), .m_axis_tlast(tl1), .ds_clk_i(ds_clk),
    .ds_data_i(ds_data), .enable(enable), .clk_detect(cd1), .overrun_cnt(ov1));

  assign tv = sel ? tv1 : tv0;
  assign td = sel ? td1 : td0;
  assign tu = sel ? tu1 : tu0;
  assign tl = sel ? tl1 : tl0;

  // Beat monitor: a beat seen valid and ready at the falling edge is taken on the next rising edge
  always @(negedge clk) begin
    cyc++;
    if (tv && tready) q.push_back('{td, tu, tl, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mod_cycle(input logic [1:0] d);
    ds_clk = 0;
    ds_data = d;
    tick;
    tick;
    ds_clk = 1;
    tick;
    tick;
    tick;
  endtask

  task automatic send_frame(input logic [3:0] c0, input logic [3:0] c1);
    for (int i = 0; i < 4; i++) mod_cycle({c1[i], c0[i]});
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (q.size() < n && t < 60) begin
      tick;
      t++;
    end
    if (q.size() < n) begin
      chk("beat_timeout", q.size(), n);
      while (q.size() < n) q.push_back('{8'h00, 1'b0, 1'b0, 0});
    end
  endtask

  task automatic chk_beat(input string name, input int i, input logic [7:0] d, input logic u, input logic l);
    chk({name, "_data"}, q[i].d, d);
    chk({name, "_user"}, q[i].u, u);
    chk({name, "_last"}, q[i].l, l);
  endtask

  initial begin
    vt[0] = '{4'b0111, 4'b0000, 1'b0, 8'h02, 8'hFC};
    vt[1] = '{4'b1111, 4'b0101, 1'b1, 8'h04, 8'h02};
    vt[2] = '{4'b1111, 4'b1111, 1'b0, 8'h04, 8'h04};
    vt[3] = '{4'b0000, 4'b1010, 1'b0, 8'hFC, 8'h00};
    vt[4] = '{4'b0000, 4'b0011, 1'b1, 8'h00, 8'h02};
    repeat (3) tick;
    @(negedge clk);
    chk("rst_tvalid", tv0, 0);
    chk("rst_tdata", td0, 0);
    chk("rst_tuser", tu0, 0);
    chk("rst_tlast", tl0, 0);
    chk("rst_clk_detect", cd0, 0);
    chk("rst_overrun", ov0, 0);
    tick;
    rst = 0;
    enable = 1;
    tready = 1;
    sel = 0;
    q.delete();
    for (int i = 0; i < 3; i++) mod_cycle(2'b01);
    ds_clk = 0;
    ds_data = 2'b00;
    tick;
    tick;
    ds_clk = 1;
    repeat (3) @(negedge clk);
    chk("lat_pre", tv0, 0);
    @(negedge clk);
    chk("lat_post", tv0, 1);
    wait_beats(2);
    chk_beat("lat_b0", 0, 8'h02, 0, 0);
    chk_beat("lat_b1", 1, 8'hFC, 1, 1);
    for (int i = 0; i < 5; i++) begin
      q.delete();
      sel = vt[i].u;
      send_frame(vt[i].c0, vt[i].c1);
      wait_beats(2);
      repeat (3) tick;
      chk($sformatf("vec%0d_count", i), q.size(), 2);
      chk_beat($sformatf("vec%0d_b0", i), 0, vt[i].e0, 0, 0);
      chk_beat($sformatf("vec%0d_b1", i), 1, vt[i].e1, 1, 1);
    end
    sel = 0;
    chk("vec_overrun", ov0, 0);
    tready = 0;
    q.delete();
    send_frame(4'b0111, 4'b0000);
    chk("stall_tvalid", tv0, 1);
    for (int f = 0; f < 3; f++) begin
      send_frame(4'b1111, 4'b1111);
      chk($sformatf("stall%0d_data", f), td0, 8'h02);
      chk($sformatf("stall%0d_user", f), tu0, 0);
    end
    chk("stall_overrun", ov0, 3);
    tready = 1;
    wait_beats(2);
    chk_beat("stall_b0", 0, 8'h02, 0, 0);
    chk_beat("stall_b1", 1, 8'hFC, 1, 1);
    tready = 0;
    q.delete();
    send_frame(4'b1111, 4'b0000);
    for (int i = 0; i < 3; i++) mod_cycle(2'b10);
    ds_clk = 0;
    ds_data = 2'b10;
    tick;
    tick;
    ds_clk = 1;
    tick;
    tready = 1;
    wait_beats(4);
    chk_beat("coin_b0", 0, 8'h04, 0, 0);
    chk_beat("coin_b1", 1, 8'hFC, 1, 1);
    chk_beat("coin_b2", 2, 8'hFC, 0, 0);
    chk_beat("coin_b3", 3, 8'h04, 1, 1);
    chk("coin_no_idle", q[2].c - q[1].c, 1);
    chk("coin_overrun", ov0, 3);
    q.delete();
    mod_cycle(2'b00);
    mod_cycle(2'b00);
    enable = 0;
    repeat (5) tick;
    enable = 1;
    send_frame(4'b1111, 4'b1111);
    wait_beats(2);
    repeat (10) tick;
    chk("en_count", q.size(), 2);
    chk_beat("en_b0", 0, 8'h04, 0, 0);
    chk_beat("en_b1", 1, 8'h04, 1, 1);
    enable = 0;
    ds_clk = 0;
    tick;
    tick;
    ds_clk = 1;
    repeat (258) @(negedge clk);
    chk("cd_hold", cd0, 1);
    @(negedge clk);
    chk("cd_drop", cd0, 0);
    repeat (40) @(negedge clk);
    chk("cd_stays_low", cd0, 0);
    tick;
    ds_clk = 0;
    tick;
    tick;
    ds_clk = 1;
    repeat (3) @(negedge clk);
    chk("cd_pre_rise", cd0, 0);
    @(negedge clk);
    chk("cd_rise", cd0, 1);
    tick;
    enable = 1;
    tready = 0;
    send_frame(4'b0111, 4'b0000);
    chk("rstmid_tvalid", tv0, 1);
    chk("rstmid_overrun_pre", ov0, 3);
    rst = 1;
    tick;
    @(negedge clk);
    chk("rstmid_tvalid_low", tv0, 0);
    chk("rstmid_overrun", ov0, 0);
    chk("rstmid_tdata", td0, 0);
    chk("rstmid_tlast", tl0, 0);
    tick;
    rst = 0;
    tready = 1;
    q.delete();
    repeat (10) tick;
    chk("rstmid_no_beats", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
